// File: rtl/ramen_pkg.sv
// Shared types and shop tables for the ramen order processor.
// Tables are sized for the default shop (4 ramen types, 5 ingredients).
package ramen_pkg;

  localparam int DEF_NUM_TYPES = 4;
  localparam int DEF_NUM_ING   = 5;

  // Ingredient indices, matching the column order of CAP and NEED
  localparam int ING_NOODLE   = 0;
  localparam int ING_BROTH    = 1;
  localparam int ING_TONKOTSU = 2;
  localparam int ING_MISO     = 3;
  localparam int ING_SOY      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELL   = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Per-ingredient storage capacity (noodle, broth, tonkotsu, miso, soy)
  localparam logic [15:0] CAP [DEF_NUM_ING] = '{
    16'd12000, 16'd41000, 16'd9000, 16'd1000, 16'd1500
  };

  // Price per ramen type
  localparam logic [15:0] PRICE [DEF_NUM_TYPES] = '{
    16'd200, 16'd250, 16'd200, 16'd250
  };

  // Recipe need per [type][portion: 0 small, 1 large][ingredient]
  localparam logic [15:0] NEED [DEF_NUM_TYPES][2][DEF_NUM_ING] = '{
    '{ '{16'd100, 16'd300, 16'd150, 16'd0,  16'd0 },
       '{16'd150, 16'd500, 16'd200, 16'd0,  16'd0 } },
    '{ '{16'd0,   16'd300, 16'd100, 16'd0,  16'd30},
       '{16'd0,   16'd500, 16'd150, 16'd0,  16'd50} },
    '{ '{16'd0,   16'd400, 16'd0,   16'd30, 16'd0 },
       '{16'd0,   16'd650, 16'd0,   16'd50, 16'd0 } },
    '{ '{16'd0,   16'd300, 16'd70,  16'd15, 16'd15},
       '{16'd0,   16'd500, 16'd100, 16'd25, 16'd25} }
  };

endpackage

// File: rtl/ramen_stock_check.sv
// Combinational stock evaluation: recipe sufficiency check, consumption,
// and the saturating restock adder applied on top of the post-order stock.
module ramen_stock_check
  import ramen_pkg::*;
#(
  parameter int NUM_ING = 5,
  parameter int STOCK_W = 16,
  parameter int TYPE_W  = 2,
  parameter int ING_W   = 3
) (
  input  logic [NUM_ING*STOCK_W-1:0] stock,
  input  logic [TYPE_W-1:0]          ramen_type,
  input  logic                       portion,
  input  logic                       order_en,
  input  logic                       restock_en,
  input  logic [ING_W-1:0]           restock_ing,
  input  logic [STOCK_W-1:0]         restock_amt,
  output logic                       ok,
  output logic [NUM_ING*STOCK_W-1:0] stock_next
);

  logic [NUM_ING*STOCK_W-1:0] stock_after;
  logic [STOCK_W:0]           sum;

  // Check recipe against current stock, consume on success, then restock
  always_comb begin
    ok          = 1'b1;
    stock_after = stock;
    stock_next  = '0;
    sum         = '0;
    for (int i = 0; i < NUM_ING; i++) begin
      if (stock[i*STOCK_W +: STOCK_W] < STOCK_W'(NEED[ramen_type][portion][i]))
        ok = 1'b0;
    end
    if (order_en && ok) begin
      for (int i = 0; i < NUM_ING; i++)
        stock_after[i*STOCK_W +: STOCK_W] =
          stock[i*STOCK_W +: STOCK_W] - STOCK_W'(NEED[ramen_type][portion][i]);
    end
    stock_next = stock_after;
    // Indices with no matching ingredient simply never hit
    for (int i = 0; i < NUM_ING; i++) begin
      if (restock_en && (restock_ing == ING_W'(i))) begin
        sum = {1'b0, stock_after[i*STOCK_W +: STOCK_W]} + {1'b0, restock_amt};
        if (sum > {1'b0, STOCK_W'(CAP[i])})
          stock_next[i*STOCK_W +: STOCK_W] = STOCK_W'(CAP[i]);
        else
          stock_next[i*STOCK_W +: STOCK_W] = sum[STOCK_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ramen_kitchen.sv
// Ramen shop order processor: single-cycle orders, stock bookkeeping,
// sold/fail counters and an end-of-session revenue report.
//
// state     | meaning
// ST_IDLE   | between sessions; orders/restocks accepted, selling rise starts session
// ST_SELL   | session open; selling fall starts the report
// ST_REPORT | one MAC step per type, index rep_idx 0..NUM_TYPES-1
// ST_DONE   | report outputs valid for one cycle; stock and counters reset on exit
module ramen_kitchen
  import ramen_pkg::*;
#(
  parameter int NUM_TYPES = 4,
  parameter int NUM_ING   = 5,
  parameter int STOCK_W   = 16,
  parameter int CNT_W     = 7,
  parameter int GAIN_W    = 18,
  parameter int TYPE_W    = $clog2(NUM_TYPES),
  parameter int ING_W     = $clog2(NUM_ING)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       selling,
  input  logic                       in_valid,
  input  logic [TYPE_W-1:0]          ramen_type,
  input  logic                       portion,
  input  logic                       restock_valid,
  input  logic [ING_W-1:0]           restock_ing,
  input  logic [STOCK_W-1:0]         restock_amt,
  output logic                       out_valid_order,
  output logic                       success,
  output logic                       out_valid_tot,
  output logic [NUM_TYPES*CNT_W-1:0] sold_num,
  output logic [CNT_W-1:0]           fail_num,
  output logic [GAIN_W-1:0]          total_gain
);

  state_t                     state;
  logic [NUM_ING*STOCK_W-1:0] stock;
  logic [NUM_ING*STOCK_W-1:0] stock_next;
  logic [NUM_ING*STOCK_W-1:0] cap_vec;
  logic [CNT_W-1:0]           sold [NUM_TYPES];
  logic [NUM_TYPES*CNT_W-1:0] sold_pack;
  logic [CNT_W-1:0]           fail_cnt;
  logic [GAIN_W-1:0]          acc;
  logic [GAIN_W-1:0]          mac_prod;
  logic [TYPE_W-1:0]          rep_idx;
  logic                       open_state;
  logic                       order_acc;
  logic                       restock_en;
  logic                       ok;

  assign open_state = (state == ST_IDLE) || (state == ST_SELL);
  assign order_acc  = in_valid && selling && open_state;
  assign restock_en = restock_valid && open_state;

  // The single multiplier of the report MAC
  assign mac_prod = GAIN_W'(sold[rep_idx]) * GAIN_W'(PRICE[rep_idx]);

  ramen_stock_check #(
    .NUM_ING (NUM_ING),
    .STOCK_W (STOCK_W),
    .TYPE_W  (TYPE_W),
    .ING_W   (ING_W)
  ) u_stock_check (
    .stock       (stock),
    .ramen_type  (ramen_type),
    .portion     (portion),
    .order_en    (order_acc),
    .restock_en  (restock_en),
    .restock_ing (restock_ing),
    .restock_amt (restock_amt),
    .ok          (ok),
    .stock_next  (stock_next)
  );

  // Capacity vector used for reset and end-of-session reload
  always_comb begin
    cap_vec = '0;
    for (int i = 0; i < NUM_ING; i++)
      cap_vec[i*STOCK_W +: STOCK_W] = STOCK_W'(CAP[i]);
  end

  // Pack sold counters with type 0 in the most significant field
  always_comb begin
    sold_pack = '0;
    for (int k = 0; k < NUM_TYPES; k++)
      sold_pack[(NUM_TYPES-k)*CNT_W-1 -: CNT_W] = sold[k];
  end

  // Session FSM, stock/counter updates, report MAC and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      stock           <= cap_vec;
      for (int k = 0; k < NUM_TYPES; k++) sold[k] <= '0;
      fail_cnt        <= '0;
      acc             <= '0;
      rep_idx         <= '0;
      out_valid_order <= 1'b0;
      success         <= 1'b0;
      out_valid_tot   <= 1'b0;
      sold_num        <= '0;
      fail_num        <= '0;
      total_gain      <= '0;
    end else begin
      out_valid_order <= order_acc;
      success         <= order_acc && ok;
      stock           <= stock_next;
      if (order_acc) begin
        if (ok) begin
          if (sold[ramen_type] != {CNT_W{1'b1}})
            sold[ramen_type] <= sold[ramen_type] + 1'b1;
        end else if (fail_cnt != {CNT_W{1'b1}}) begin
          fail_cnt <= fail_cnt + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (selling) state <= ST_SELL;
        end
        ST_SELL: begin
          if (!selling) begin
            state   <= ST_REPORT;
            rep_idx <= '0;
            acc     <= '0;
          end
        end
        ST_REPORT: begin
          acc     <= acc + mac_prod;
          rep_idx <= rep_idx + 1'b1;
          if (rep_idx == TYPE_W'(NUM_TYPES-1)) begin
            state         <= ST_DONE;
            out_valid_tot <= 1'b1;
            total_gain    <= acc + mac_prod;
            sold_num      <= sold_pack;
            fail_num      <= fail_cnt;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          out_valid_tot <= 1'b0;
          total_gain    <= '0;
          sold_num      <= '0;
          fail_num      <= '0;
          stock         <= cap_vec;
          for (int k = 0; k < NUM_TYPES; k++) sold[k] <= '0;
          fail_cnt      <= '0;
          acc           <= '0;
          rep_idx       <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramen_kitchen.sv
// Self-checking bench for ramen_kitchen: directed sessions plus randomized
// traffic, compared cycle by cycle against a behavioural shop model.
module tb_ramen_kitchen;

  localparam int NT = 4;
  localparam int NI = 5;
  localparam int CW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        selling;
  logic        in_valid;
  logic [1:0]  ramen_type;
  logic        portion;
  logic        restock_valid;
  logic [2:0]  restock_ing;
  logic [15:0] restock_amt;
  logic        out_valid_order;
  logic        success;
  logic        out_valid_tot;
  logic [27:0] sold_num;
  logic [6:0]  fail_num;
  logic [17:0] total_gain;

  always #5 clk = ~clk;

  ramen_kitchen dut (
    .clk             (clk),
    .rst             (rst),
    .selling         (selling),
    .in_valid        (in_valid),
    .ramen_type      (ramen_type),
    .portion         (portion),
    .restock_valid   (restock_valid),
    .restock_ing     (restock_ing),
    .restock_amt     (restock_amt),
    .out_valid_order (out_valid_order),
    .success         (success),
    .out_valid_tot   (out_valid_tot),
    .sold_num        (sold_num),
    .fail_num        (fail_num),
    .total_gain      (total_gain)
  );

  int checks   = 0;
  int failures = 0;

  // Shop tables
  int m_cap[NI]   = '{12000, 41000, 9000, 1000, 1500};
  int m_price[NT] = '{200, 250, 200, 250};
  int m_need[NT][2][NI] = '{
    '{'{100, 300, 150, 0, 0},  '{150, 500, 200, 0, 0}},
    '{'{0, 300, 100, 0, 30},   '{0, 500, 150, 0, 50}},
    '{'{0, 400, 0, 30, 0},     '{0, 650, 0, 50, 0}},
    '{'{0, 300, 70, 15, 15},   '{0, 500, 100, 25, 25}}
  };

  // Model state: stock, counters, and cycles left until the shop reopens
  int m_stock[NI];
  int m_sold[NT];
  int m_fail;
  int rep_left;
  bit in_sell;

  int          cyc;
  int          drop_cyc;
  int          tot_cyc;
  int          tot_pulses;
  int          last_gain;
  int          last_fail;
  logic [27:0] last_sold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) m_stock[i] = m_cap[i];
    for (int k = 0; k < NT; k++) m_sold[k] = 0;
    m_fail   = 0;
    rep_left = 0;
    in_sell  = 1'b0;
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic step(input bit r, input bit s, input bit v, input int ty, input bit po,
                      input bit rv, input int ri, input int ra);
    bit          zone;
    bit          ok;
    bit          e_ov;
    bit          e_succ;
    bit          e_tot;
    logic [27:0] e_sold;
    int          e_gain;
    int          e_fail;
    rst           = r;
    selling       = s;
    in_valid      = v;
    ramen_type    = ty[1:0];
    portion       = po;
    restock_valid = rv;
    restock_ing   = ri[2:0];
    restock_amt   = ra[15:0];
    @(posedge clk);
    e_ov   = 1'b0;
    e_succ = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      zone = (rep_left == 0);
      if (zone && s && v) begin
        ok = 1'b1;
        for (int i = 0; i < NI; i++)
          if (m_stock[i] < m_need[ty][po][i]) ok = 1'b0;
        e_ov   = 1'b1;
        e_succ = ok;
        if (ok) begin
          for (int i = 0; i < NI; i++) m_stock[i] -= m_need[ty][po][i];
          if (m_sold[ty] < 127) m_sold[ty]++;
        end else if (m_fail < 127) begin
          m_fail++;
        end
      end
      if (zone && rv && ri < NI)
        m_stock[ri] = (m_stock[ri] + ra > m_cap[ri]) ? m_cap[ri] : m_stock[ri] + ra;
      if (rep_left > 0) begin
        rep_left--;
        if (rep_left == 0) model_reset();
      end else if (in_sell && !s) begin
        rep_left = NT + 1;
        in_sell  = 1'b0;
        drop_cyc = cyc;
      end else if (s) begin
        in_sell = 1'b1;
      end
    end
    e_tot  = (rep_left == 1);
    e_sold = '0;
    e_gain = 0;
    e_fail = 0;
    if (e_tot) begin
      for (int k = 0; k < NT; k++) begin
        e_sold |= 28'(m_sold[k]) << ((NT - 1 - k) * CW);
        e_gain += m_sold[k] * m_price[k];
      end
      e_fail = m_fail;
    end
    #1;
    check_val("out_valid_order", {31'd0, out_valid_order}, {31'd0, e_ov});
    check_val("success", {31'd0, success}, {31'd0, e_succ});
    check_val("out_valid_tot", {31'd0, out_valid_tot}, {31'd0, e_tot});
    check_val("sold_num", {4'd0, sold_num}, {4'd0, e_sold});
    check_val("fail_num", {25'd0, fail_num}, 32'(e_fail));
    check_val("total_gain", {14'd0, total_gain}, 32'(e_gain));
    if (out_valid_tot) begin
      tot_pulses++;
      tot_cyc   = cyc + 1;
      last_gain = int'(total_gain);
      last_fail = int'(fail_num);
      last_sold = sold_num;
    end
    cyc++;
  endtask

  task automatic order(input int ty, input bit po);
    step(1'b0, 1'b1, 1'b1, ty, po, 1'b0, 0, 0);
  endtask

  task automatic end_session();
    for (int i = 0; i < NT + 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    cyc        = 0;
    drop_cyc   = 0;
    tot_cyc    = 0;
    tot_pulses = 0;
    last_gain  = 0;
    last_fail  = 0;
    last_sold  = '0;
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 100);
    check_val("rst_out_valid_order", {31'd0, out_valid_order}, 32'd0);
    check_val("rst_out_valid_tot", {31'd0, out_valid_tot}, 32'd0);
    check_val("rst_total_gain", {14'd0, total_gain}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);

    // Three type0 large, two type3 small
    for (int i = 0; i < 3; i++) order(0, 1'b1);
    for (int i = 0; i < 2; i++) order(3, 1'b0);
    end_session();
    check_val("t1_gain", 32'(last_gain), 32'd1100);
    check_val("t1_sold", {4'd0, last_sold}, {4'd0, 7'd3, 7'd0, 7'd0, 7'd2});
    check_val("t1_report_latency", 32'(tot_cyc - drop_cyc), 32'd5);

    // Miso runs out after 20 type2 large
    for (int i = 0; i < 21; i++) order(2, 1'b1);
    check_val("t2_21st_success", {31'd0, success}, 32'd0);
    end_session();
    check_val("t2_fail", 32'(last_fail), 32'd1);
    check_val("t2_gain", 32'(last_gain), 32'd4000);

    // Same-cycle order and restock: order sees pre-restock stock
    for (int i = 0; i < 20; i++) order(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 3, 30);
    check_val("t3_order_with_restock", {31'd0, success}, 32'd0);
    order(2, 1'b0);
    check_val("t3_after_restock", {31'd0, success}, 32'd1);
    order(2, 1'b0);
    check_val("t3_miso_empty_again", {31'd0, success}, 32'd0);
    end_session();

    // Noodle restock saturates at capacity; tonkotsu kept topped up
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0, 5000);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 2, 150);
    check_val("t4_120th_success", {31'd0, success}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 2, 150);
    check_val("t4_121st_success", {31'd0, success}, 32'd0);
    end_session();
    check_val("t4_gain", 32'(last_gain), 32'd24000);

    // Sold counter saturation, with soy/tonkotsu restocked alternately
    for (int i = 0; i < 130; i++)
      step(1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, (i % 2) ? 2 : 4, (i % 2) ? 200 : 60);
    end_session();
    check_val("t5_sold", {4'd0, last_sold}, {4'd0, 7'd0, 7'd127, 7'd0, 7'd0});
    check_val("t5_gain", 32'(last_gain), 32'd31750);

    // Fail counter saturation
    for (int i = 0; i < 150; i++) order(2, 1'b1);
    end_session();
    check_val("t6_fail_sat", 32'(last_fail), 32'd127);

    // Randomized sessions with junk traffic around the report
    for (int sess = 0; sess < 4; sess++) begin
      for (int c = 0; c < 80; c++)
        step(1'b0, 1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 3000));
      for (int c = 0; c < 10; c++)
        step(1'b0, (c < 2) ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), $urandom_range(0, 5000));
      end_session();
    end

    // Reset during REPORT aborts the report; next session starts from capacity
    for (int i = 0; i < 3; i++) order(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    tot_pulses = 0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check_val("t7_rst_tot", {31'd0, out_valid_tot}, 32'd0);
    check_val("t7_rst_sold", {4'd0, sold_num}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    check_val("t7_no_report", 32'(tot_pulses), 32'd0);
    for (int i = 0; i < 20; i++) order(2, 1'b1);
    check_val("t7_20th_from_cap", {31'd0, success}, 32'd1);
    order(2, 1'b1);
    check_val("t7_21st", {31'd0, success}, 32'd0);
    end_session();
    check_val("t7_gain", 32'(last_gain), 32'd4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
